// File: rtl/fp_normalize_round.sv
// Post-add normalize/round stage of the single-precision FP adder.
// Normalizes one bit per cycle, rounds to nearest-even and packs an IEEE-754 word.
// Holds one op at a time, with a valid/ready handshake on both sides.
module fp_normalize_round #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXP_W-1:0]         in_exp,
  input  logic [MANT_W-1:0]        in_mant,
  input  logic                     in_cout,
  input  logic [2:0]               in_grs,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MANT_W-1:0]  out_result,
  output logic                     out_overflow,
  output logic                     out_zero
);

  localparam int RES_W = EXP_W + MANT_W;
  localparam int FRAC_W = MANT_W - 1;
  // Largest biased exponent; reaching it after rounding means infinity.
  localparam logic [EXP_W:0] EXP_INF = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                c_q, c_d;
  logic [MANT_W-1:0]   m_q, m_d;
  logic                g_q, g_d;
  logic                r_q, r_d;
  logic                s_q, s_d;
  logic [EXP_W:0]      e_q, e_d;
  logic                sign_q, sign_d;
  logic [RES_W-1:0]    res_q, res_d;
  logic                ovf_q, ovf_d;
  logic                zero_q, zero_d;

  // Rounding datapath temporaries.
  logic                inc;
  logic [MANT_W:0]     sum;
  logic [MANT_W-1:0]   m_rnd;
  logic [EXP_W:0]      e_rnd;

  assign in_ready     = (state_q == ST_IDLE) && !rst;
  assign out_valid    = (state_q == ST_DONE);
  assign out_result   = res_q;
  assign out_overflow = ovf_q;
  assign out_zero     = zero_q;

  // Next-state and datapath: accept, normalize one step, round/pack, hand off.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    m_d     = m_q;
    g_d     = g_q;
    r_d     = r_q;
    s_d     = s_q;
    e_d     = e_q;
    sign_d  = sign_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    inc     = g_q & (r_q | s_q | m_q[0]);
    sum     = {1'b0, m_q} + {{MANT_W{1'b0}}, inc};
    m_rnd   = sum[MANT_W-1:0];
    e_rnd   = e_q;
    if (sum[MANT_W]) begin
      // Rounding overflowed the mantissa: renormalize to 1.000...
      m_rnd = {1'b1, {(MANT_W-1){1'b0}}};
      e_rnd = e_q + EXP_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          c_d     = in_cout;
          m_d     = in_mant;
          g_d     = in_grs[2];
          r_d     = in_grs[1];
          s_d     = in_grs[0];
          // A zero exponent denotes the subnormal range, which has scale 2^(1-bias).
          e_d     = (in_exp == '0) ? EXP_ONE : {1'b0, in_exp};
          sign_d  = in_sign;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (c_q) begin
          m_d     = {1'b1, m_q[MANT_W-1:1]};
          g_d     = m_q[0];
          r_d     = g_q;
          s_d     = r_q | s_q;
          e_d     = e_q + EXP_ONE;
          c_d     = 1'b0;
          state_d = ST_ROUND;
        end else if (m_q == '0 && !(g_q | r_q | s_q)) begin
          res_d   = {sign_q, {(RES_W-1){1'b0}}};
          ovf_d   = 1'b0;
          zero_d  = 1'b1;
          state_d = ST_DONE;
        end else if (m_q[MANT_W-1]) begin
          state_d = ST_ROUND;
        end else if (e_q == EXP_ONE) begin
          // Minimum exponent: leave the result subnormal.
          state_d = ST_ROUND;
        end else begin
          m_d = {m_q[MANT_W-2:0], g_q};
          g_d = r_q;
          r_d = 1'b0;
          e_d = e_q - EXP_ONE;
        end
      end
      ST_ROUND: begin
        zero_d = 1'b0;
        if (e_rnd >= EXP_INF) begin
          res_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          ovf_d = 1'b1;
        end else begin
          // No hidden bit means subnormal, encoded with a zero exponent field.
          res_d = {sign_q, (m_rnd[MANT_W-1] ? e_rnd[EXP_W-1:0] : {EXP_W{1'b0}}),
                   m_rnd[FRAC_W-1:0]};
          ovf_d = 1'b0;
        end
        m_d     = m_rnd;
        e_d     = e_rnd;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          res_d   = '0;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      c_q     <= 1'b0;
      m_q     <= '0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
      e_q     <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      m_q     <= m_d;
      g_q     <= g_d;
      r_q     <= r_d;
      s_q     <= s_d;
      e_q     <= e_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

endmodule
